// File: rtl/rc4_sbox_ctrl_if.sv
// Bundles the key-buffer, cipher handshake and three S-box RAM ports of rc4_sbox_ctrl.
// master = sequencer side, slave = key buffer / cipher datapath / RAM side.
interface rc4_sbox_ctrl_if;
  logic       key_setup_en;
  logic [7:0] key_len;
  logic [7:0] key_addr;
  logic [7:0] key_byte;
  logic       cipher_req;
  logic       cipher_ready;
  logic       cipher_valid;
  logic [7:0] ks_byte;
  logic [7:0] raddr_1;
  logic [7:0] rdata_1;
  logic       wen_2;
  logic [7:0] waddr_2;
  logic [7:0] wdata_2;
  logic       wen_3;
  logic [7:0] addr_3;
  logic [7:0] wdata_3;
  logic [7:0] rdata_3;

  modport master (
    input  key_setup_en, key_len, key_byte, cipher_req, rdata_1, rdata_3,
    output key_addr, cipher_ready, cipher_valid, ks_byte,
           raddr_1, wen_2, waddr_2, wdata_2, wen_3, addr_3, wdata_3
  );

  modport slave (
    output key_setup_en, key_len, key_byte, cipher_req, rdata_1, rdata_3,
    input  key_addr, cipher_ready, cipher_valid, ks_byte,
           raddr_1, wen_2, waddr_2, wdata_2, wen_3, addr_3, wdata_3
  );
endinterface

// File: rtl/rc4_sbox_ctrl.sv
// RC4 S-box sequencer: identity fill, KSA, then one PRGA keystream byte per accepted cipher_req.
// Setup 1280 busy cycles; keystream valid 6 cycles after accept; requests only taken while cipher_ready.
module rc4_sbox_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  rc4_sbox_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, K1, K2, K3, K4, READY, P1, P2, P3, P4, P5
  } state_t;

  state_t     state;
  logic [7:0] i, j, n, kidx, kb, si, sj;
  logic [8:0] klen;

  logic       ready_q, valid_q, wen_2_q, wen_3_q;
  logic [7:0] key_addr_q, ks_q, raddr_1_q, waddr_2_q, wdata_2_q, addr_3_q, wdata_3_q;

  logic       start;
  logic [7:0] j_sum, kidx_nxt, ks_fwd;

  always_comb begin
    start    = bus.key_setup_en && ((state == IDLE) || (state == READY));
    j_sum    = j + bus.rdata_1 + ((state == K2) ? kb : 8'd0);
    kidx_nxt = (({1'b0, kidx} + 9'd1) == klen) ? 8'd0 : kidx + 8'd1;
    // The keystream read was issued alongside the swap writes, so patch in the swapped entries.
    if (raddr_1_q == j)
      ks_fwd = si;
    else if (raddr_1_q == i)
      ks_fwd = sj;
    else
      ks_fwd = bus.rdata_1;
  end

  assign bus.key_addr     = key_addr_q;
  assign bus.cipher_ready = ready_q;
  assign bus.cipher_valid = valid_q;
  assign bus.ks_byte      = ks_q;
  assign bus.raddr_1      = raddr_1_q;
  assign bus.wen_2        = wen_2_q;
  assign bus.waddr_2      = waddr_2_q;
  assign bus.wdata_2      = wdata_2_q;
  assign bus.wen_3        = wen_3_q;
  // The j lookup must reach the RAM in the same cycle S[i] arrives to keep 4 cycles per step.
  assign bus.addr_3       = ((state == K2) || (state == P2)) ? j_sum : addr_3_q;
  assign bus.wdata_3      = wdata_3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= 8'd0;
      j          <= 8'd0;
      n          <= 8'd0;
      kidx       <= 8'd0;
      kb         <= 8'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      klen       <= 9'd0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      wen_2_q    <= 1'b0;
      wen_3_q    <= 1'b0;
      key_addr_q <= 8'd0;
      ks_q       <= 8'd0;
      raddr_1_q  <= 8'd0;
      waddr_2_q  <= 8'd0;
      wdata_2_q  <= 8'd0;
      addr_3_q   <= 8'd0;
      wdata_3_q  <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      wen_2_q <= 1'b0;
      wen_3_q <= 1'b0;
      if (start) begin
        state     <= INIT;
        n         <= 8'd0;
        klen      <= (bus.key_len == 8'd0) ? 9'd256 : {1'b0, bus.key_len};
        ready_q   <= 1'b0;
        wen_2_q   <= 1'b1;
        waddr_2_q <= 8'd0;
        wdata_2_q <= 8'd0;
      end else begin
        case (state)
          IDLE: ;
          INIT: begin
            if (n == 8'hFF) begin
              state      <= K1;
              i          <= 8'd0;
              j          <= 8'd0;
              kidx       <= 8'd0;
              raddr_1_q  <= 8'd0;
              key_addr_q <= 8'd0;
            end else begin
              n         <= n + 8'd1;
              wen_2_q   <= 1'b1;
              waddr_2_q <= n + 8'd1;
              wdata_2_q <= n + 8'd1;
            end
          end
          K1: begin
            kb    <= bus.key_byte;
            state <= K2;
          end
          K2, P2: begin
            si       <= bus.rdata_1;
            j        <= j_sum;
            addr_3_q <= j_sum;
            state    <= (state == K2) ? K3 : P3;
          end
          K3, P3: begin
            sj        <= bus.rdata_3;
            wen_2_q   <= 1'b1;
            waddr_2_q <= i;
            wdata_2_q <= bus.rdata_3;
            wen_3_q   <= 1'b1;
            addr_3_q  <= j;
            wdata_3_q <= si;
            if (state == P3) begin
              raddr_1_q <= si + bus.rdata_3;
              state     <= P4;
            end else begin
              state     <= K4;
            end
          end
          K4: begin
            if (i == 8'hFF) begin
              state   <= READY;
              ready_q <= 1'b1;
              i       <= 8'd0;
              j       <= 8'd0;
            end else begin
              state      <= K1;
              i          <= i + 8'd1;
              kidx       <= kidx_nxt;
              raddr_1_q  <= i + 8'd1;
              key_addr_q <= kidx_nxt;
            end
          end
          READY: begin
            if (bus.cipher_req) begin
              state     <= P1;
              ready_q   <= 1'b0;
              i         <= i + 8'd1;
              raddr_1_q <= i + 8'd1;
            end
          end
          P1: state <= P2;
          P4: state <= P5;
          P5: begin
            ks_q    <= ks_fwd;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state   <= READY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// Directed bench for rc4_sbox_ctrl with a behavioural 3-port S-box RAM and key buffer.
module tb_rc4_sbox_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rc4_sbox_ctrl_if bus ();
  rc4_sbox_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem    [0:255];
  logic [7:0] keybuf [0:255];
  logic [7:0] exp_ks [0:15];
  logic [7:0] key_exp  [0:9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] wiki_exp [0:5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};

  // Read-old-data RAM; port 3 is written last so it wins on a shared address.
  always @(posedge clk) begin
    if (bus.wen_2) mem[bus.waddr_2] <= bus.wdata_2;
    if (bus.wen_3) mem[bus.addr_3]  <= bus.wdata_3;
    bus.rdata_1 <= mem[bus.raddr_1];
    bus.rdata_3 <= mem[bus.addr_3];
  end
  assign bus.key_byte = keybuf[bus.key_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  logic         mon_en = 1'b0, mon_clr = 1'b0;
  logic [255:0] ka_seen;
  logic [7:0]   ka_prev;
  int           ka_chg;

  always @(negedge clk) begin
    if (bus.cipher_valid) vcount++;
    if (mon_clr) begin
      ka_seen = '0;
      ka_prev = 8'd0;
      ka_chg  = 0;
    end else if (mon_en) begin
      if (bus.key_addr != ka_prev) ka_chg++;
      ka_seen[bus.key_addr] = 1'b1;
      ka_prev = bus.key_addr;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {5'd0, bus.cipher_ready, bus.cipher_valid, bus.ks_byte, bus.key_addr, bus.raddr_1,
            bus.wen_2, bus.waddr_2, bus.wdata_2, bus.wen_3, bus.addr_3, bus.wdata_3};
  endfunction

  task automatic load_key(input int kl, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    for (int k = 0; k < 256; k++) keybuf[k] = 8'(k);
    if (kl != 0) begin
      keybuf[0] = b0; keybuf[1] = b1; keybuf[2] = b2; keybuf[3] = b3;
    end
  endtask

  task automatic start_setup(input int kl, input logic req);
    @(negedge clk);
    bus.key_len      = 8'(kl);
    bus.key_setup_en = 1'b1;
    bus.cipher_req   = req;
    @(posedge clk);
    #1 bus.key_setup_en = 1'b0;
  endtask

  // ready must show in the 1281st cycle after the sampling edge, i.e. 1280 edges later.
  task automatic setup(input string tag, input int kl, input logic req);
    int v0;
    start_setup(kl, req);
    v0 = vcount;
    chk({tag, "_ready_drop"}, 64'(bus.cipher_ready), 64'd0);
    repeat (1279) @(posedge clk);
    #1 chk({tag, "_ready_1279"}, 64'(bus.cipher_ready), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_ready_1280"}, 64'(bus.cipher_ready), 64'd1);
    bus.cipher_req = 1'b0;
    chk({tag, "_no_valid_in_setup"}, 64'(vcount - v0), 64'd0);
  endtask

  // valid is high in the 6th cycle after the accepting edge: 5 edges later.
  task automatic get_byte(input string tag, input logic [7:0] exp);
    int lat = 0;
    logic [7:0] b = 8'd0;
    @(negedge clk);
    bus.cipher_req = 1'b1;
    @(posedge clk);
    #1 bus.cipher_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.cipher_valid) begin
        lat = c;
        b   = bus.ks_byte;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_byte"}, 64'(b), 64'(exp));
  endtask

  task automatic rc4_model(input int kl, input int nb);
    logic [7:0] s [0:255];
    logic [7:0] t;
    int jj, ii;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      jj = (jj + int'(s[k]) + int'(keybuf[k % kl])) % 256;
      t = s[k]; s[k] = s[jj]; s[jj] = t;
    end
    ii = 0; jj = 0;
    for (int k = 0; k < nb; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      exp_ks[k] = s[(int'(s[ii]) + int'(s[jj])) % 256];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v0, got, last;
    rst_n = 1'b0;
    bus.key_setup_en = 1'b0;
    bus.key_len = 8'd0;
    bus.cipher_req = 1'b0;
    load_key(3, 8'h4B, 8'h65, 8'h79, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;

    // "Key" with cipher_req held high through setup, then ten single requests.
    setup("key", 3, 1'b1);
    for (int k = 0; k < 10; k++) get_byte($sformatf("key_b%0d", k), key_exp[k]);
    repeat (3) @(posedge clk);
    #1 chk("ks_hold", 64'({bus.cipher_valid, bus.ks_byte}), 64'({1'b0, 8'h19}));

    // Rekey mid-stream with req and setup_en together: setup must win.
    setup("rekey", 3, 1'b1);
    for (int k = 0; k < 3; k++) get_byte($sformatf("rekey_b%0d", k), key_exp[k]);

    // "Wiki" with cipher_req held high: one byte every 6 cycles.
    load_key(4, 8'h57, 8'h69, 8'h6B, 8'h69);
    setup("wiki", 4, 1'b0);
    v0 = vcount; got = 0; last = 0;
    @(negedge clk);
    bus.cipher_req = 1'b1;
    for (int c = 1; c <= 60 && got < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.cipher_valid) begin
        chk($sformatf("wiki_b%0d", got), 64'(bus.ks_byte), 64'(wiki_exp[got]));
        chk($sformatf("wiki_gap%0d", got), 64'(c - last), 64'd6);
        last = c;
        got++;
        if (got == 6) bus.cipher_req = 1'b0;
      end
    end
    repeat (20) @(posedge clk);
    chk("wiki_count", 64'(vcount - v0), 64'd6);

    // Reset while in K3 of i=5 (K3 is entered 258 + 4*i edges after sampling).
    load_key(3, 8'h4B, 8'h65, 8'h79, 8'h00);
    start_setup(3, 1'b0);
    repeat (278) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_k3_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    setup("after_k3", 3, 1'b0);
    for (int k = 0; k < 4; k++) get_byte($sformatf("after_k3_b%0d", k), key_exp[k]);

    // Reset during P4 while both swap writes are active.
    @(negedge clk);
    bus.cipher_req = 1'b1;
    @(posedge clk);
    #1 bus.cipher_req = 1'b0;
    v0 = vcount;
    repeat (3) @(posedge clk);
    #1 chk("p4_writes_active", 64'({bus.wen_2, bus.wen_3}), 64'd3);
    rst_n = 1'b0;
    #1 chk("rst_p4_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cipher_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.cipher_req = 1'b0;
    chk("idle_ignores_req", 64'({bus.cipher_ready, 31'd0}) | 64'(vcount - v0), 64'd0);
    setup("after_p4", 3, 1'b0);
    for (int k = 0; k < 3; k++) get_byte($sformatf("after_p4_b%0d", k), key_exp[k]);

    // key_len = 0: a full 256-byte key, checked against the software model.
    do_reset();
    load_key(0, 8'h00, 8'h00, 8'h00, 8'h00);
    rc4_model(256, 16);
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) begin mon_clr = 1'b0; mon_en = 1'b1; end
    setup("len0", 0, 1'b0);
    mon_en = 1'b0;
    chk("len0_ka_all_seen", 64'(&ka_seen), 64'd1);
    chk("len0_ka_changes", 64'(ka_chg), 64'd255);
    for (int k = 0; k < 16; k++) get_byte($sformatf("len0_b%0d", k), exp_ks[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
